cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_W, default 3, number of set-index bits (2**INDEX_W sets).
REQ-002 SHALL have port clk, input, 1, sole clock, all state updated on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port cpu_req, input, 1, CPU request valid, sampled in IDLE only.
REQ-005 SHALL have port cpu_wr, input, 1, 1=write, 0=read.
REQ-006 SHALL have port cpu_addr, input, 7+INDEX_W, {tag[5], index[INDEX_W], word[2]}, MSB first.
REQ-007 SHALL have port cpu_wdata, input, 16, write data.
REQ-008 SHALL have ports cpu_rdata (output, 16, read data), cpu_ack (output, 1, one-cycle completion pulse) and cpu_ready (output, 1, high only in IDLE).
REQ-009 SHALL have set-side outputs set_sel (INDEX_W), set_en, set_rst, set_comp, set_write, set_valid_in (1 each), set_word (2), set_tag (5), set_data (16).
REQ-010 SHALL have set-side inputs set_ack, set_hit, set_dirty, set_valid (1 each), set_tag_out (5), set_data_out (16).
REQ-011 SHALL have memory ports mem_req, mem_wr (outputs, 1), mem_addr (output, 7+INDEX_W), mem_wdata (output, 16), mem_rdata (input, 16), mem_ack (input, 1).

Function
REQ-012 SHALL be the initiator for the set protocol: hold set_en and all set_* fields stable until set_ack=1, capture set outputs that cycle, then drive set_en=0 for at least one cycle before the next set operation.
REQ-013 SHALL hold mem_req, mem_wr, mem_addr, mem_wdata stable until mem_ack=1, capture mem_rdata that cycle, drop mem_req the next cycle.
REQ-014 SHALL implement states INIT, IDLE, COMP, WB, FILL, DONE.
REQ-015 INIT: SHALL issue set_en with set_rst=1 to set_sel 0..2**INDEX_W-1 in order, then enter IDLE; cpu_req ignored during INIT.
REQ-016 IDLE: on cpu_req=1 SHALL latch cpu_wr, cpu_addr, cpu_wdata and enter COMP; latched values SHALL not change until DONE.
REQ-017 COMP: SHALL issue compare op (set_comp=1, set_write=latched wr, set_tag, set_word, set_data); on ack with set_hit=1 and set_valid=1 go to DONE, else go to WB if set_valid=1 and set_dirty=1, otherwise FILL.
REQ-018 WB: for word 0..3 SHALL access-read (comp=0, write=0) the set, then memory-write set_data_out to {set_tag_out, index, word}; then enter FILL.
REQ-019 FILL: for word 0..3 SHALL memory-read {latched tag, index, word}, then access-write (comp=0, write=1, set_valid_in=1, set_tag=latched tag) that word; then return to COMP (write-allocate; retried compare hits).
REQ-020 DONE: SHALL pulse cpu_ack for exactly one cycle with cpu_rdata = captured set_data_out for reads (0 for writes), then enter IDLE.
REQ-021 Hit latency: cpu_req to cpu_ack SHALL depend only on set_ack delay; with set_ack in the first enable cycle, 4 cycles.
REQ-022 Word counter SHALL be 2 bits, wrap 3->0 marks end of WB/FILL loop.
REQ-023 cpu_req while not IDLE SHALL be ignored; no request queueing.

Reset
REQ-024 On rst=1, asynchronously: state=INIT, all outputs 0 (cpu_ready=0, cpu_ack=0, set_en=0, mem_req=0), counters 0, latched request discarded, including mid-WB or mid-FILL.
REQ-025 After rst release SHALL always perform full INIT sweep before cpu_ready=1.

Configuration
REQ-026 With CACHE_CTRL_STATS_EN defined SHALL add outputs hit_cnt and miss_cnt (16 each), incremented once per request at first COMP result, saturating at 16'hFFFF, cleared by rst; without it those ports and counters SHALL not exist and behaviour is otherwise identical.

Verification
REQ-027 Reset release, INDEX_W=3, immediate set_ack -> exactly 8 set_rst ops on set_sel 0..7, then cpu_ready=1.
REQ-028 Read miss, clean line, addr tag=5'h03 index=2 word=1, mem returns 16'hA000+word -> 4 mem reads, 4 access-writes, re-compare hit, cpu_rdata=16'hA001, one cpu_ack.
REQ-029 Write hit to same line word=2 data 16'h1234, then read miss to tag=5'h07 index=2 -> 4 mem writes to tag 5'h03 with word 2 = 16'h1234, then fill from tag 5'h07.
REQ-030 set_ack delayed 5 cycles in COMP -> set_en and fields held stable 5 cycles, cpu_ack still single-cycle.
REQ-031 rst asserted during FILL word 2 -> all outputs 0 same cycle, INIT restarts after release.
REQ-032 With CACHE_CTRL_STATS_EN, 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// Bundle of CPU, cache-set and memory handshake signals for cache_ctrl.
// master = controller view, slave = environment (CPU, set array, memory) view.
interface cache_ctrl_if #(
  parameter int INDEX_W = 3
);
  localparam int ADDR_W = 7 + INDEX_W;

  logic               cpu_req;
  logic               cpu_wr;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [15:0]        cpu_wdata;
  logic [15:0]        cpu_rdata;
  logic               cpu_ack;
  logic               cpu_ready;

  logic [INDEX_W-1:0] set_sel;
  logic               set_en;
  logic               set_rst;
  logic               set_comp;
  logic               set_write;
  logic               set_valid_in;
  logic [1:0]         set_word;
  logic [4:0]         set_tag;
  logic [15:0]        set_data;
  logic               set_ack;
  logic               set_hit;
  logic               set_dirty;
  logic               set_valid;
  logic [4:0]         set_tag_out;
  logic [15:0]        set_data_out;

  logic               mem_req;
  logic               mem_wr;
  logic [ADDR_W-1:0]  mem_addr;
  logic [15:0]        mem_wdata;
  logic [15:0]        mem_rdata;
  logic               mem_ack;

  modport master (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_ready,
    output set_sel, set_en, set_rst, set_comp, set_write, set_valid_in,
    output set_word, set_tag, set_data,
    input  set_ack, set_hit, set_dirty, set_valid, set_tag_out, set_data_out,
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_ready,
    input  set_sel, set_en, set_rst, set_comp, set_write, set_valid_in,
    input  set_word, set_tag, set_data,
    output set_ack, set_hit, set_dirty, set_valid, set_tag_out, set_data_out,
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller sequencing one set array and memory.
// Optional hit/miss statistics counters are enabled with `define CACHE_CTRL_STATS_EN.
//
// state | meaning
// INIT  | sweep set_rst over every set (step 0 gap, step 1 enable)
// IDLE  | cpu_ready, latch request on cpu_req
// COMP  | compare op (step 0), decide hit / WB / FILL (step 1, set_en low)
// WB    | per word: set read (0), memory write (1), mem_req drop (2)
// FILL  | per word: memory read (0), set write (1), set_en gap (2)
// DONE  | one-cycle cpu_ack
module cache_ctrl #(
  parameter int INDEX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  cache_ctrl_if.master bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);
  localparam int ADDR_W = 7 + INDEX_W;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_COMP, S_WB, S_FILL, S_DONE
  } state_t;

  state_t             state, state_n;
  logic [1:0]         step, step_n;
  logic [1:0]         word;
  logic [INDEX_W-1:0] init_sel;

  logic               lat_wr;
  logic [4:0]         lat_tag;
  logic [INDEX_W-1:0] lat_idx;
  logic [1:0]         lat_word;
  logic [15:0]        lat_wdata;
  logic               first_comp;

  logic               cap_hit, cap_valid, cap_dirty;
  logic [4:0]         cap_tag;
  logic [15:0]        cap_data;
  logic [15:0]        fill_data;

  logic               comp_hit;
  assign comp_hit = cap_hit & cap_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
      step  <= 2'd0;
    end else begin
      state <= state_n;
      step  <= step_n;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    case (state)
      S_INIT: begin
        if (step == 2'd0) step_n = 2'd1;
        else if (bus.set_ack) begin
          step_n = 2'd0;
          if (&init_sel) state_n = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.cpu_req) begin
          state_n = S_COMP;
          step_n  = 2'd0;
        end
      end
      S_COMP: begin
        if (step == 2'd0) begin
          if (bus.set_ack) step_n = 2'd1;
        end else begin
          step_n = 2'd0;
          if (comp_hit)                    state_n = S_DONE;
          else if (cap_valid && cap_dirty) state_n = S_WB;
          else                             state_n = S_FILL;
        end
      end
      S_WB: begin
        case (step)
          2'd0:    if (bus.set_ack) step_n = 2'd1;
          2'd1:    if (bus.mem_ack) step_n = 2'd2;
          default: begin
            step_n = 2'd0;
            if (word == 2'd3) state_n = S_FILL;
          end
        endcase
      end
      S_FILL: begin
        case (step)
          2'd0:    if (bus.mem_ack) step_n = 2'd1;
          2'd1:    if (bus.set_ack) step_n = 2'd2;
          default: begin
            step_n = 2'd0;
            if (word == 2'd3) state_n = S_COMP;
          end
        endcase
      end
      S_DONE:  state_n = S_IDLE;
      default: begin
        state_n = S_INIT;
        step_n  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word       <= 2'd0;
      init_sel   <= '0;
      lat_wr     <= 1'b0;
      lat_tag    <= 5'd0;
      lat_idx    <= '0;
      lat_word   <= 2'd0;
      lat_wdata  <= 16'd0;
      first_comp <= 1'b0;
      cap_hit    <= 1'b0;
      cap_valid  <= 1'b0;
      cap_dirty  <= 1'b0;
      cap_tag    <= 5'd0;
      cap_data   <= 16'd0;
      fill_data  <= 16'd0;
    end else begin
      if (state == S_INIT && step == 2'd1 && bus.set_ack && !(&init_sel))
        init_sel <= init_sel + 1'b1;
      if (state == S_IDLE && bus.cpu_req) begin
        lat_wr     <= bus.cpu_wr;
        lat_tag    <= bus.cpu_addr[ADDR_W-1 -: 5];
        lat_idx    <= bus.cpu_addr[2 +: INDEX_W];
        lat_word   <= bus.cpu_addr[1:0];
        lat_wdata  <= bus.cpu_wdata;
        first_comp <= 1'b1;
      end
      if (bus.set_en && bus.set_ack) begin
        cap_hit   <= bus.set_hit;
        cap_valid <= bus.set_valid;
        cap_dirty <= bus.set_dirty;
        cap_tag   <= bus.set_tag_out;
        cap_data  <= bus.set_data_out;
      end
      if (state == S_FILL && step == 2'd0 && bus.mem_ack)
        fill_data <= bus.mem_rdata;
      if (state == S_COMP && step == 2'd1) begin
        first_comp <= 1'b0;
        word       <= 2'd0;
      end
      // the 2-bit wrap from 3 back to 0 is what ends the WB/FILL loop
      if ((state == S_WB || state == S_FILL) && step == 2'd2)
        word <= word + 2'd1;
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
    end else if (state == S_COMP && step == 2'd1 && first_comp) begin
      if (comp_hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

  always_comb begin
    bus.cpu_rdata    = 16'd0;
    bus.cpu_ack      = 1'b0;
    bus.cpu_ready    = 1'b0;
    bus.set_sel      = (state == S_INIT) ? init_sel : lat_idx;
    bus.set_en       = 1'b0;
    bus.set_rst      = 1'b0;
    bus.set_comp     = 1'b0;
    bus.set_write    = 1'b0;
    bus.set_valid_in = 1'b0;
    bus.set_word     = 2'd0;
    bus.set_tag      = 5'd0;
    bus.set_data     = 16'd0;
    bus.mem_req      = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = 16'd0;
    case (state)
      S_INIT: begin
        if (step == 2'd1) begin
          bus.set_en  = 1'b1;
          bus.set_rst = 1'b1;
        end
      end
      S_IDLE: bus.cpu_ready = 1'b1;
      S_COMP: begin
        if (step == 2'd0) begin
          bus.set_en       = 1'b1;
          bus.set_comp     = 1'b1;
          bus.set_write    = lat_wr;
          bus.set_valid_in = lat_wr;
          bus.set_word     = lat_word;
          bus.set_tag      = lat_tag;
          bus.set_data     = lat_wdata;
        end
      end
      S_WB: begin
        if (step == 2'd0) begin
          bus.set_en   = 1'b1;
          bus.set_word = word;
        end else if (step == 2'd1) begin
          bus.mem_req   = 1'b1;
          bus.mem_wr    = 1'b1;
          bus.mem_addr  = {cap_tag, lat_idx, word};
          bus.mem_wdata = cap_data;
        end
      end
      S_FILL: begin
        if (step == 2'd0) begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = {lat_tag, lat_idx, word};
        end else if (step == 2'd1) begin
          bus.set_en       = 1'b1;
          bus.set_write    = 1'b1;
          bus.set_valid_in = 1'b1;
          bus.set_word     = word;
          bus.set_tag      = lat_tag;
          bus.set_data     = fill_data;
        end
      end
      S_DONE: begin
        bus.cpu_ack   = 1'b1;
        bus.cpu_rdata = lat_wr ? 16'd0 : cap_data;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural set array and memory, directed CPU vector table plus
// hand-written reset, INIT-sweep, slow set_ack and reset-during-FILL sequences.
module tb_cache_ctrl;
  localparam int INDEX_W = 3;
  localparam int AW      = 7 + INDEX_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_ctrl_if #(.INDEX_W(INDEX_W)) bus ();
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  cache_ctrl #(.INDEX_W(INDEX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  // set array model
  bit        s_valid [8];
  bit        s_dirty [8];
  bit [4:0]  s_tag   [8];
  bit [15:0] s_data  [8][4];
  int        comp_delay = 0;
  int        en_cnt = 0;

  assign bus.set_ack      = bus.set_en && (en_cnt >= (bus.set_comp ? comp_delay : 0));
  assign bus.set_valid    = s_valid[bus.set_sel];
  assign bus.set_dirty    = s_dirty[bus.set_sel];
  assign bus.set_tag_out  = s_tag[bus.set_sel];
  assign bus.set_data_out = s_data[bus.set_sel][bus.set_word];
  assign bus.set_hit      = bus.set_comp && s_valid[bus.set_sel] && (s_tag[bus.set_sel] == bus.set_tag);

  always @(posedge clk) begin
    if (bus.set_en && !bus.set_ack) en_cnt <= en_cnt + 1;
    else en_cnt <= 0;
    if (bus.set_en && bus.set_ack) begin
      if (bus.set_rst) begin
        s_valid[bus.set_sel] <= 1'b0;
        s_dirty[bus.set_sel] <= 1'b0;
      end else if (bus.set_comp) begin
        if (bus.set_write && bus.set_hit) begin
          s_data[bus.set_sel][bus.set_word] <= bus.set_data;
          s_dirty[bus.set_sel] <= 1'b1;
        end
      end else if (bus.set_write) begin
        s_data[bus.set_sel][bus.set_word] <= bus.set_data;
        s_tag[bus.set_sel]   <= bus.set_tag;
        s_valid[bus.set_sel] <= bus.set_valid_in;
        s_dirty[bus.set_sel] <= 1'b0;
      end
    end
  end

  // memory model: unwritten locations read as 16'hA000 + word
  bit [15:0] mem     [1024];
  bit        mem_vld [1024];
  bit        mem_ack_r = 1'b0;
  logic [15:0] mem_dflt;
  assign mem_dflt      = 16'hA000 + {14'd0, bus.mem_addr[1:0]};
  assign bus.mem_ack   = mem_ack_r;
  assign bus.mem_rdata = mem_vld[bus.mem_addr] ? mem[bus.mem_addr] : mem_dflt;

  // activity monitor
  int rst_ops = 0, init_order_err = 0, comp_ops = 0, comp_en_cycles = 0;
  int mem_rd = 0, mem_wr = 0, ack_pulses = 0;
  int set_hold_err = 0, set_gap_err = 0, mem_hold_err = 0, mem_drop_err = 0;
  int exp_init_sel = 0;
  logic        p_en = 0, p_sack = 0, p_mreq = 0, p_mack = 0;
  logic [32:0] p_sf = '0;
  logic [26:0] p_mf = '0;
  logic [32:0] sf;
  logic [26:0] mf;
  assign sf = {bus.set_sel, bus.set_rst, bus.set_comp, bus.set_write, bus.set_valid_in,
               bus.set_word, bus.set_tag, bus.set_data};
  assign mf = {bus.mem_wr, bus.mem_addr, bus.mem_wdata};

  always @(posedge clk) begin
    mem_ack_r <= bus.mem_req && !mem_ack_r;
    if (bus.mem_req && bus.mem_ack) begin
      if (bus.mem_wr) begin
        mem[bus.mem_addr]     <= bus.mem_wdata;
        mem_vld[bus.mem_addr] <= 1'b1;
        mem_wr <= mem_wr + 1;
      end else mem_rd <= mem_rd + 1;
    end
    if (rst) exp_init_sel <= 0;
    else begin
      if (bus.set_en && bus.set_ack && bus.set_rst) begin
        rst_ops <= rst_ops + 1;
        if (int'(bus.set_sel) != exp_init_sel) init_order_err <= init_order_err + 1;
        exp_init_sel <= exp_init_sel + 1;
      end
      if (bus.set_en && bus.set_ack && bus.set_comp) comp_ops <= comp_ops + 1;
      if (bus.set_en && bus.set_comp) comp_en_cycles <= comp_en_cycles + 1;
      if (bus.cpu_ack) ack_pulses <= ack_pulses + 1;
      if (p_en && !p_sack && (!bus.set_en || sf != p_sf)) set_hold_err <= set_hold_err + 1;
      if (p_en && p_sack && bus.set_en) set_gap_err <= set_gap_err + 1;
      if (p_mreq && !p_mack && (!bus.mem_req || mf != p_mf)) mem_hold_err <= mem_hold_err + 1;
      if (p_mreq && p_mack && bus.mem_req) mem_drop_err <= mem_drop_err + 1;
    end
    p_en <= bus.set_en; p_sack <= bus.set_ack; p_sf <= sf;
    p_mreq <= bus.mem_req; p_mack <= bus.mem_ack; p_mf <= mf;
  end

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk_addr(input logic [4:0] tag, input logic [2:0] idx,
                                            input logic [1:0] word);
    return {tag, idx, word};
  endfunction

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (bus.cpu_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // lat = negedges from the request until cpu_ack is seen (0 if it never came)
  task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rdata, output int lat);
    logic ok;
    rdata = 16'hxxxx;
    lat = 0;
    wait_ready(ok);
    if (!ok) return;
    bus.cpu_req = 1'b1; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      bus.cpu_req = 1'b0;
      if (bus.cpu_ack) begin
        lat = c;
        rdata = bus.cpu_rdata;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_init(input string tag, input int ops0, input int ord0, input int cmp0);
    logic ok;
    wait_ready(ok);
    check({tag, "_ready"}, {31'd0, ok}, 32'd1);
    check({tag, "_rst_ops"}, rst_ops - ops0, 32'd8);
    check({tag, "_sel_order"}, init_order_err - ord0, 32'd0);
    check({tag, "_no_comp"}, comp_ops - cmp0, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [AW-1:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_rd;
    int          exp_wr;
    int          exp_lat;   // 0: not a hit, latency not pinned
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] rd;
    int lat, r0, w0, a0, o0, c0, e0;
    logic ok;

    vecs[0] = '{"rd_miss_clean", 1'b0, mk_addr(5'h03, 3'd2, 2'd1), 16'h0000, 16'hA001, 4, 0, 0};
    vecs[1] = '{"wr_hit",        1'b1, mk_addr(5'h03, 3'd2, 2'd2), 16'h1234, 16'h0000, 0, 0, 3};
    vecs[2] = '{"rd_hit_wdata",  1'b0, mk_addr(5'h03, 3'd2, 2'd2), 16'h0000, 16'h1234, 0, 0, 3};
    vecs[3] = '{"rd_miss_dirty", 1'b0, mk_addr(5'h07, 3'd2, 2'd0), 16'h0000, 16'hA000, 4, 4, 0};
    vecs[4] = '{"rd_refill_wb",  1'b0, mk_addr(5'h03, 3'd2, 2'd2), 16'h0000, 16'h1234, 4, 0, 0};
    vecs[5] = '{"wr_miss_alloc", 1'b1, mk_addr(5'h01, 3'd5, 2'd3), 16'hBEEF, 16'h0000, 4, 0, 0};
    vecs[6] = '{"rd_hit_alloc",  1'b0, mk_addr(5'h01, 3'd5, 2'd3), 16'h0000, 16'hBEEF, 0, 0, 3};
    vecs[7] = '{"rd_hit_w0",     1'b0, mk_addr(5'h01, 3'd5, 2'd0), 16'h0000, 16'hA000, 0, 0, 3};

    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.cpu_ready}, 32'd0);
    check("rst_outs", {bus.cpu_ack, bus.set_en, bus.mem_req, bus.set_rst}, 32'd0);

    // reset release with cpu_req held during INIT: it must be ignored
    o0 = rst_ops; e0 = init_order_err; c0 = comp_ops;
    rst = 1'b0;
    bus.cpu_req = 1'b1;
    repeat (4) @(negedge clk);
    check("init_not_ready", {31'd0, bus.cpu_ready}, 32'd0);
    bus.cpu_req = 1'b0;
    check_init("init", o0, e0, c0);

    foreach (vecs[i]) begin
      r0 = mem_rd; w0 = mem_wr; a0 = ack_pulses;
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, lat);
      check({vecs[i].name, "_acked"}, {31'd0, lat > 0}, 32'd1);
      check({vecs[i].name, "_rdata"}, {16'd0, rd}, {16'd0, vecs[i].exp_rdata});
      check({vecs[i].name, "_mem_rd"}, mem_rd - r0, vecs[i].exp_rd);
      check({vecs[i].name, "_mem_wr"}, mem_wr - w0, vecs[i].exp_wr);
      check({vecs[i].name, "_ack_once"}, ack_pulses - a0, 32'd1);
      if (vecs[i].exp_lat != 0) check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
    end

    check("wb_word2", {16'd0, mem[mk_addr(5'h03, 3'd2, 2'd2)]}, 32'h1234);
    check("wb_word1", {16'd0, mem[mk_addr(5'h03, 3'd2, 2'd1)]}, 32'hA001);

    // slow set_ack in COMP: held 6 enable cycles (ack on the 6th), still one cpu_ack
    comp_delay = 5;
    r0 = comp_en_cycles; a0 = ack_pulses;
    do_req(1'b0, mk_addr(5'h01, 3'd5, 2'd3), 16'd0, rd, lat);
    comp_delay = 0;
    check("slow_rdata", {16'd0, rd}, 32'hBEEF);
    check("slow_lat", lat, 32'd8);
    check("slow_en_cycles", comp_en_cycles - r0, 32'd6);
    check("slow_ack_once", ack_pulses - a0, 32'd1);

`ifdef CACHE_CTRL_STATS_EN
    check("stats_hit", {16'd0, hit_cnt}, 32'd5);
    check("stats_miss", {16'd0, miss_cnt}, 32'd4);
`endif

    // reset while FILL is fetching word 2 of a miss on index 0
    wait_ready(ok);
    check("c_ready", {31'd0, ok}, 32'd1);
    r0 = mem_rd;
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = mk_addr(5'h09, 3'd0, 2'd0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (mem_rd - r0 == 2 && bus.mem_req && !bus.mem_wr) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("fill_w2_reached", {31'd0, ok}, 32'd1);
    check("fill_w2_addr", {22'd0, bus.mem_addr}, {22'd0, mk_addr(5'h09, 3'd0, 2'd2)});
    rst = 1'b1;
    #1;
    check("midrst_ctl", {bus.cpu_ready, bus.cpu_ack, bus.set_en, bus.mem_req, bus.mem_wr}, 32'd0);
    check("midrst_bus", {bus.mem_addr, bus.set_sel, bus.set_rst, bus.set_comp}, 32'd0);
`ifdef CACHE_CTRL_STATS_EN
    check("midrst_stats", {hit_cnt, miss_cnt}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    o0 = rst_ops; e0 = init_order_err; c0 = comp_ops;
    rst = 1'b0;
    check_init("reinit", o0, e0, c0);

    // dirty BEEF was discarded by reset: memory copy comes back
    r0 = mem_rd; w0 = mem_wr;
    do_req(1'b0, mk_addr(5'h01, 3'd5, 2'd3), 16'd0, rd, lat);
    check("post_rst_rdata", {16'd0, rd}, 32'hA003);
    check("post_rst_mem_rd", mem_rd - r0, 32'd4);
    check("post_rst_mem_wr", mem_wr - w0, 32'd0);

    check("set_hold", set_hold_err, 32'd0);
    check("set_gap", set_gap_err, 32'd0);
    check("mem_hold", mem_hold_err, 32'd0);
    check("mem_drop", mem_drop_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
